// File: rtl/chart_player.sv
// Chart sequencer: fetches {pitch, duration} notes from external storage and sounds each pitch
// for its duration in counted ticks, until an end marker or the last slot of the chart.
module chart_player #(
  parameter int unsigned NOTE_W    = 8,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned NOTES_MAX = 64,
  localparam int unsigned IDX_W    = $clog2(NOTES_MAX)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [7:0]              chart_id_i,
  input  logic                    stop_i,
  input  logic                    pause_i,
  input  logic                    tick_i,
  output logic [7:0]              rd_chart_id_o,
  output logic [IDX_W-1:0]        rd_note_idx_o,
  input  logic [NOTE_W+LEN_W-1:0] rd_note_data_i,
  output logic [NOTE_W-1:0]       note_out_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [IDX_W-1:0]        cur_idx_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StPlay, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         chart_q, chart_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;

  logic [NOTE_W-1:0]  rd_pitch;
  logic [LEN_W-1:0]   rd_dur;

  assign rd_pitch = rd_note_data_i[NOTE_W+LEN_W-1 -: NOTE_W];
  assign rd_dur   = rd_note_data_i[LEN_W-1:0];

  always_comb begin
    state_d     = state_q;
    chart_d     = chart_q;
    idx_d       = idx_q;
    cur_idx_d   = cur_idx_q;
    note_d      = note_q;
    remaining_d = remaining_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && (chart_id_i != 8'd0)) begin
          chart_d = chart_id_i;
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        // Storage data is valid here, one cycle after the FETCH request.
        if (rd_dur == '0) begin
          state_d = StDone;
        end else begin
          note_d      = rd_pitch;
          remaining_d = rd_dur;
          cur_idx_d   = idx_q;
          state_d     = StPlay;
        end
      end
      StPlay: begin
        if (tick_i && !pause_i) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            if (idx_q == IDX_W'(NOTES_MAX - 1)) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StDone: begin
        note_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides every other transition, including a same-cycle start or final tick.
    if (stop_i) begin
      state_d = StIdle;
      note_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      chart_q     <= '0;
      idx_q       <= '0;
      cur_idx_q   <= '0;
      note_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      chart_q     <= chart_d;
      idx_q       <= idx_d;
      cur_idx_q   <= cur_idx_d;
      note_q      <= note_d;
      remaining_q <= remaining_d;
    end
  end

  assign rd_chart_id_o = (state_q == StFetch) ? chart_q : 8'd0;
  assign rd_note_idx_o = idx_q;
  assign note_out_o    = note_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone) && !stop_i;
  assign cur_idx_o     = cur_idx_q;

endmodule

// File: tb/tb_chart_player.sv
// Bench for chart_player: storage model, note-level reference player and a queue scoreboard
// that checks fetches, sounding pitch at each tick and completion pulses.
module tb_chart_player;
  localparam int NOTES_MAX = 64;
  localparam int IDX_W     = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, pause, tick;
  logic [7:0]       chart_id;
  logic [7:0]       rd_chart_id;
  logic [IDX_W-1:0] rd_note_idx;
  logic [15:0]      rd_data;
  logic [7:0]       note_out;
  logic             busy, done;
  logic [IDX_W-1:0] cur_idx;

  logic [15:0] mem [0:7][0:NOTES_MAX-1];

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int done_exp = 0;
  int fetch_q[$];
  int note_q[$];
  int done_q[$];

  always #5 clk = ~clk;

  chart_player dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .chart_id_i     (chart_id),
    .stop_i         (stop),
    .pause_i        (pause),
    .tick_i         (tick),
    .rd_chart_id_o  (rd_chart_id),
    .rd_note_idx_o  (rd_note_idx),
    .rd_note_data_i (rd_data),
    .note_out_o     (note_out),
    .busy_o         (busy),
    .done_o         (done),
    .cur_idx_o      (cur_idx)
  );

  // Registered storage: data valid the cycle after the request.
  always @(posedge clk) begin
    if (rd_chart_id >= 8'd1 && rd_chart_id <= 8'd7) rd_data <= mem[rd_chart_id[2:0]][rd_note_idx];
    else rd_data <= 16'd0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an observable event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_chart_id != 8'd0) begin
        if (fetch_q.size() == 0) check("unexpected_fetch", int'(rd_chart_id) * 256 + int'(rd_note_idx), -1);
        else check("fetch", int'(rd_chart_id) * 256 + int'(rd_note_idx), fetch_q.pop_front());
      end
      if (tick && busy) begin
        if (note_q.size() == 0) check("unexpected_tick_note", int'(note_out) * 256 + int'(cur_idx), -1);
        else check("tick_note", int'(note_out) * 256 + int'(cur_idx), note_q.pop_front());
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) check("unexpected_done", int'(cur_idx), -1);
        else check("done_cur_idx", int'(cur_idx), done_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input bit p);
    pause    = p;
    tick     = 1'b1;
    start    = 1'($urandom_range(0, 1));  // start during playback must be ignored
    chart_id = 8'($urandom);
    cyc(1);
    tick  = 1'b0;
    start = 1'b0;
    cyc(7);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_note_out"}, int'(note_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rd_chart_id"}, int'(rd_chart_id), 0);
    check({tag, "_rd_note_idx"}, int'(rd_note_idx), 0);
    check({tag, "_cur_idx"}, int'(cur_idx), 0);
  endtask

  // Reference player. abort_mode: 0 none, 1 stop at start of note abort_note, 2 reset there.
  task automatic run_chart(input int id, input int n_pause, input int abort_mode,
                           input int abort_note);
    int pitch, dur, nxt;
    bit finished;
    finished = 1'b0;
    fetch_q.push_back(id * 256);
    start    = 1'b1;
    chart_id = 8'(id);
    cyc(1);
    start    = 1'b0;
    chart_id = 8'($urandom);
    cyc(4);
    for (int i = 0; i < NOTES_MAX && !finished; i++) begin
      pitch = int'(mem[id][i][15:8]);
      dur   = int'(mem[id][i][7:0]);
      if (abort_mode == 1 && i == abort_note) begin
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_note_out", int'(note_out), 0);
        cyc(3);
        return;
      end
      if (abort_mode == 2 && i == abort_note) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("post_reset_busy", int'(busy), 0);
        return;
      end
      for (int k = 0; k < dur; k++) begin
        if (k == 1) begin
          repeat (n_pause) begin
            note_q.push_back(pitch * 256 + i);
            do_tick(1'b1);
          end
        end
        if (k == dur - 1) begin
          nxt = (i < NOTES_MAX - 1) ? int'(mem[id][i + 1][7:0]) : 0;
          if (i < NOTES_MAX - 1) fetch_q.push_back(id * 256 + i + 1);
          if (i == NOTES_MAX - 1 || nxt == 0) begin
            done_q.push_back(i);
            done_exp++;
            finished = 1'b1;
          end
        end
        note_q.push_back(pitch * 256 + i);
        do_tick(1'b0);
      end
    end
    cyc(2);
    check("end_busy", int'(busy), 0);
    check("end_note_out", int'(note_out), 0);
  endtask

  task automatic gen_chart(input int id);
    int len;
    len = $urandom_range(1, 5);
    for (int j = 0; j < len; j++) mem[id][j] = {8'($urandom), 8'($urandom_range(1, 3))};
    mem[id][len] = 16'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < 8; c++)
      for (int j = 0; j < NOTES_MAX; j++) mem[c][j] = 16'd0;
    mem[3][0] = {8'd60, 8'd2};
    mem[3][1] = {8'd62, 8'd1};
    mem[3][2] = 16'd0;
    mem[4][0] = {8'd60, 8'd4};
    mem[4][1] = 16'd0;
    for (int j = 0; j < NOTES_MAX; j++) mem[5][j] = {8'($urandom_range(1, 255)), 8'd1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; tick = 1'b0; chart_id = 8'd0;
    #12 check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(2);

    run_chart(3, 0, 0, 0);

    start = 1'b1; chart_id = 8'd0;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("id0_busy", int'(busy), 0);

    start = 1'b1; stop = 1'b1; chart_id = 8'd3;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(2);
    check("stop_start_busy", int'(busy), 0);

    run_chart(4, 3, 0, 0);
    run_chart(3, 0, 1, 1);
    run_chart(5, 0, 0, 0);
    run_chart(3, 0, 2, 0);
    run_chart(3, 0, 0, 0);

    for (int r = 0; r < 16; r++) begin
      gen_chart(6 + (r % 2));
      run_chart(6 + (r % 2), $urandom_range(0, 2), 0, 0);
    end

    cyc(4);
    check("fetch_q_left", fetch_q.size(), 0);
    check("note_q_left", note_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/chart_player.md
CHART_PLAYER -- requirements
Module: chart_player

Interface
REQ-001 Parameter NOTE_W, default 8, pitch code width; pitch 0 = rest.
REQ-002 Parameter LEN_W, default 8, note duration width in ticks; duration 0 = end-of-chart marker.
REQ-003 Parameter NOTES_MAX, default 64, maximum notes per chart; IDX_W = clog2(NOTES_MAX).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to play chart_id.
REQ-007 chart_id  in  8  chart to play, 1-based; 0 invalid.
REQ-008 stop  in  1  abort playback.
REQ-009 pause  in  1  level; freezes duration countdown while high.
REQ-010 tick  in  1  one-cycle beat pulse from tempo timer.
REQ-011 rd_chart_id  out  8  storage read request, 1-based; 0 = no access.
REQ-012 rd_note_idx  out  IDX_W  note index within requested chart.
REQ-013 rd_note_data  in  NOTE_W+LEN_W  {pitch, duration}, registered by storage, valid the cycle after the request.
REQ-014 note_out  out  NOTE_W  pitch currently sounding.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done  out  1  one-cycle pulse on natural chart completion.
REQ-017 cur_idx  out  IDX_W  index of note currently playing.

Function
REQ-018 States SHALL be IDLE, FETCH, WAIT, PLAY, DONE.
REQ-019 IDLE: start=1 with chart_id!=0 latches chart_id, clears index to 0, enters FETCH; start with chart_id=0 ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 FETCH (exactly one cycle): rd_chart_id = latched id, rd_note_idx = index; next state WAIT.
REQ-022 rd_chart_id SHALL be 0 in every state other than FETCH.
REQ-023 WAIT (exactly one cycle): duration field 0 -> DONE; else note_out <= pitch, remaining <= duration, cur_idx <= index, enter PLAY.
REQ-024 PLAY: tick=1 and pause=0 decrements remaining; tick while pause=1 has no effect.
REQ-025 PLAY: counted tick with remaining=1 -> DONE if index=NOTES_MAX-1, else index+1 and FETCH.
REQ-026 note_out SHALL hold the previous pitch through FETCH/WAIT (no gap to 0 between notes).
REQ-027 tick during FETCH or WAIT SHALL be ignored; tick spacing of at least 4 cycles is a system precondition.
REQ-028 DONE lasts one cycle: done=1, note_out <= 0, next state IDLE.
REQ-029 stop=1 in any state: next state IDLE, note_out <= 0, rd_chart_id 0, no done pulse.
REQ-030 stop and start in the same cycle: stop wins; no playback starts.
REQ-031 stop and final counted tick in the same cycle: stop wins; done stays 0.
REQ-032 Latched chart id SHALL not change during playback regardless of chart_id input.
REQ-033 Index arithmetic SHALL never wrap; completion at NOTES_MAX-1 per REQ-025.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, note_out=0, busy=0, done=0, rd_chart_id=0, rd_note_idx=0, cur_idx=0, remaining=0.
REQ-035 Reset mid-playback SHALL abandon the chart with no done pulse; after release, playback only resumes on a new start.

Verification
REQ-036 Chart 3 = {(60,2),(62,1),(0,0)}; start chart_id=3, tick every 8 cycles -> rd_chart_id=3 with idx 0,1,2 in successive FETCH cycles; note_out 60 for 2 ticks, then 62 for 1 tick; done pulses once; note_out=0; busy falls.
REQ-037 start with chart_id=0 -> rd_chart_id stays 0, busy stays 0.
REQ-038 Playing (60,4), pause high across 3 ticks, then released -> 60 lasts 4 counted ticks, 7 ticks total.
REQ-039 stop asserted during second note -> next cycle IDLE, note_out=0, done never asserted.
REQ-040 Chart with NOTES_MAX entries, all duration 1 -> done after 64th counted tick; rd_note_idx never exceeds 63.
REQ-041 rst_n pulsed low mid-note -> outputs reach reset values without a clock edge; start after release replays from index 0.
